mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; address width is fixed at 8 bits and data width at 32 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous, active-high reset
REQ-003 The block SHALL expose the CPU requester port:
- cpu_req  input  1  access request, held until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  8  word address
- cpu_wdata  input  32  write data
- cpu_gnt  output  1  one-cycle pulse: access accepted
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  output  32  read data
REQ-004 The block SHALL expose a debug requester port (dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata) with the same widths and meanings as REQ-003.
REQ-005 The block SHALL expose the memory port:
- mem_addr  output  8  word address
- mem_we  output  1  write strobe
- mem_wdata  output  32  write data
- mem_rdata  input  32  synchronous read data, valid one cycle after address
REQ-006 The block SHALL expose busy  output  1, high whenever the state is not IDLE.

Function
REQ-007 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-008 IDLE: if either req is high, the FSM SHALL latch the winner as owner and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-009 ADDR: the block SHALL drive the owner's addr, wdata and we onto mem_addr, mem_wdata and mem_we, pulse the owner's gnt, and go to DATA.
REQ-010 DATA: if the owner access is a read, the block SHALL drive owner rdata = mem_rdata and pulse the owner's rvalid; mem_we SHALL be 0.
REQ-011 DATA: if either req is high, the FSM SHALL arbitrate and go directly to ADDR; otherwise it SHALL go to IDLE. Sustained throughput is one access per 2 cycles.
REQ-012 Arbitration SHALL be round-robin on a 1-bit last-granted register: a single request wins outright; when both request, the port that was not last granted wins.
REQ-013 The last-granted register SHALL update on entry to ADDR.
REQ-014 Requester inputs SHALL be sampled only in the cycle that arbitration is made; a req still high in the DATA cycle is a new request.
REQ-015 Writes SHALL produce no rvalid pulse.
REQ-016 mem_we SHALL be high only in ADDR with a write owner.
REQ-017 The non-owner gnt and rvalid SHALL stay 0.
REQ-018 A rdata output SHALL hold its last value when its rvalid is low.
REQ-019 mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-020 Worst-case wait from req to gnt SHALL be 4 cycles with both ports continuously requesting (no starvation).

Reset
REQ-021 Asserting rst SHALL immediately force: state IDLE, last-granted = dbg (so cpu wins the first tie), and all gnt, rvalid, mem_we and busy = 0.
REQ-022 Asserting rst SHALL also force cpu_rdata, dbg_rdata, mem_addr and mem_wdata = 0.
REQ-023 Reset during ADDR SHALL abort the write: mem_we drops asynchronously and no gnt or rvalid completes.
REQ-024 The first arbitration after reset release SHALL occur on the first rising edge with rst low.

Verification
REQ-025 Single read: cpu_req=1, we=0, addr=0x10, mem[0x10]=0xDEADBEEF -> cpu_gnt in cycle 1, cpu_rvalid with cpu_rdata=0xDEADBEEF in cycle 2, then IDLE.
REQ-026 Single write: dbg write 0x12345678 to 0x05 -> mem_we=1 for exactly 1 cycle with mem_addr=0x05; readback of 0x05 returns 0x12345678; no dbg_rvalid on the write.
REQ-027 Simultaneous requests after reset, both held for 8 accesses -> grants alternate cpu, dbg, cpu, dbg, ... with one grant every 2 cycles and no idle cycle between them.
REQ-028 Single requester back-to-back: cpu reads addresses 0..3 continuously -> 4 grants in 8 cycles, rdata = mem[0..3] in order.
REQ-029 Reset mid-write: rst asserted in the ADDR cycle of a write to 0x20 -> mem_we=0 within the same cycle, busy=0, mem[0x20] unchanged, and the next tie is granted to cpu.
REQ-030 Late request: dbg_req rises in the DATA cycle of a cpu access -> dbg_gnt is asserted in the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (cpu, dbg) in front of a single synchronous-read memory.
// Each access spends one ADDR cycle (grant, address/write strobe) and one DATA cycle (read return).
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [7:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [7:0]  mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   // last-granted port, which is also the owner of the access in flight (0 = cpu, 1 = dbg)
   logic        last;
   logic        win;
   logic        any_req;
   logic        we_q;
   logic [7:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] cpu_rdata_q;
   logic [31:0] dbg_rdata_q;
   logic        in_addr;
   logic        in_data;

   assign any_req = cpu_req | dbg_req;

   always_comb begin
      win = dbg_req;
      if (cpu_req && dbg_req) begin
         win = ~last;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = any_req ? ADDR : IDLE;
         ADDR:    state_nxt = DATA;
         DATA:    state_nxt = any_req ? ADDR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Requester inputs are captured only at the edge that enters ADDR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 32'h0;
         cpu_rdata_q <= 32'h0;
         dbg_rdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state_nxt == ADDR) begin
            last    <= win;
            we_q    <= win ? dbg_we    : cpu_we;
            addr_q  <= win ? dbg_addr  : cpu_addr;
            wdata_q <= win ? dbg_wdata : cpu_wdata;
         end
         if (cpu_rvalid) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (dbg_rvalid) begin
            dbg_rdata_q <= mem_rdata;
         end
      end
   end

   assign in_addr = (state == ADDR);
   assign in_data = (state == DATA);

   assign cpu_gnt    = in_addr & ~last;
   assign dbg_gnt    = in_addr &  last;
   assign cpu_rvalid = in_data & ~we_q & ~last;
   assign dbg_rvalid = in_data & ~we_q &  last;

   // Read data passes straight through in DATA and is held from a register otherwise.
   assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

   assign mem_we    = in_addr & we_q;
   assign mem_addr  = in_addr ? addr_q  : 8'h00;
   assign mem_wdata = in_addr ? wdata_q : 32'h0;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory behind it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, dbg_addr;
   logic [31:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
   logic        busy;

   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [31:0] bd_data;
   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // Memory model: backdoor preload port, write on mem_we, registered read.
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      bd_we = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      bd_we = 0; bd_addr = 0; bd_data = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);

      for (int i = 0; i < 4; i++) preload(i[7:0], 32'hA000_0000 + i);
      preload(8'h10, 32'hDEAD_BEEF);
      preload(8'h20, 32'hAAAA_5555);
      preload(8'h05, 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // single cpu read
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      tick();
      chk("rd_cpu_gnt", cpu_gnt, 1);
      chk("rd_dbg_gnt", dbg_gnt, 0);
      chk("rd_busy", busy, 1);
      chk("rd_mem_addr", mem_addr, 8'h10);
      chk("rd_mem_we", mem_we, 0);
      cpu_req = 0;
      tick();
      chk("rd_cpu_gnt_off", cpu_gnt, 0);
      chk("rd_cpu_rvalid", cpu_rvalid, 1);
      chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("rd_dbg_rvalid", dbg_rvalid, 0);
      tick();
      chk("rd_idle_busy", busy, 0);
      chk("rd_rvalid_off", cpu_rvalid, 0);
      chk("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
      chk("rd_idle_addr", mem_addr, 0);

      // single dbg write, then readback
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h05; dbg_wdata = 32'h1234_5678;
      tick();
      chk("wr_dbg_gnt", dbg_gnt, 1);
      chk("wr_cpu_gnt", cpu_gnt, 0);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 8'h05);
      chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
      dbg_req = 0; dbg_we = 0;
      tick();
      chk("wr_mem_we_data", mem_we, 0);
      chk("wr_no_rvalid", dbg_rvalid, 0);
      tick();
      chk("wr_mem_we_idle", mem_we, 0);
      chk("wr_idle_wdata", mem_wdata, 0);
      dbg_req = 1; dbg_addr = 8'h05;
      tick();
      chk("rb_dbg_gnt", dbg_gnt, 1);
      dbg_req = 0;
      tick();
      chk("rb_dbg_rvalid", dbg_rvalid, 1);
      chk("rb_dbg_rdata", dbg_rdata, 32'h1234_5678);
      chk("rb_cpu_hold", cpu_rdata, 32'hDEAD_BEEF);
      chk("rb_cpu_rvalid", cpu_rvalid, 0);
      tick();

      // both requesting continuously after reset: strict alternation, no idle cycles
      rst = 1; tick(); rst = 0;
      cpu_req = 1; cpu_addr = 8'h00; dbg_req = 1; dbg_addr = 8'h01;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
         chk("rr_dbg_gnt", dbg_gnt, (i % 2 == 1) ? 1 : 0);
         tick();
         chk("rr_busy", busy, 1);
         if (i % 2 == 0) begin
            chk("rr_cpu_rvalid", cpu_rvalid, 1);
            chk("rr_cpu_rdata", cpu_rdata, 32'hA000_0000);
            chk("rr_dbg_rvalid", dbg_rvalid, 0);
         end else begin
            chk("rr_dbg_rvalid", dbg_rvalid, 1);
            chk("rr_dbg_rdata", dbg_rdata, 32'hA000_0001);
            chk("rr_cpu_rvalid", cpu_rvalid, 0);
         end
         if (i == 7) begin
            cpu_req = 0; dbg_req = 0;
         end
      end
      tick();
      chk("rr_end_idle", busy, 0);

      // single requester back-to-back over addresses 0..3
      cpu_req = 1; cpu_addr = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("b2b_gnt", cpu_gnt, 1);
         cpu_addr = 8'(i + 1);
         tick();
         chk("b2b_rvalid", cpu_rvalid, 1);
         chk("b2b_rdata", cpu_rdata, 32'hA000_0000 + i);
         if (i == 3) cpu_req = 0;
      end
      tick();
      chk("b2b_idle", busy, 0);

      // reset in the ADDR cycle of a cpu write to 0x20
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 32'h0BAD_F00D;
      tick();
      chk("rw_gnt_before", cpu_gnt, 1);
      chk("rw_we_before", mem_we, 1);
      cpu_req = 0; cpu_we = 0;
      rst = 1;
      #1;
      chk("rw_mem_we_async", mem_we, 0);
      chk("rw_busy_async", busy, 0);
      chk("rw_gnt_async", cpu_gnt, 0);
      tick();
      chk("rw_rvalid", cpu_rvalid, 0);
      rst = 0;
      cpu_req = 1; cpu_addr = 8'h20; dbg_req = 1; dbg_addr = 8'h05;
      tick();
      chk("rw_tie_cpu", cpu_gnt, 1);
      chk("rw_tie_dbg", dbg_gnt, 0);
      cpu_req = 0;
      tick();
      chk("rw_unchanged", cpu_rdata, 32'hAAAA_5555);
      tick();
      chk("rw_dbg_next", dbg_gnt, 1);
      dbg_req = 0;
      tick();
      chk("rw_dbg_rdata", dbg_rdata, 32'h1234_5678);
      tick();

      // dbg request rising during the DATA cycle of a cpu access
      cpu_req = 1; cpu_addr = 8'h02;
      tick();
      chk("late_cpu_gnt", cpu_gnt, 1);
      cpu_req = 0;
      tick();
      chk("late_cpu_rdata", cpu_rdata, 32'hA000_0002);
      dbg_req = 1; dbg_addr = 8'h03;
      tick();
      chk("late_dbg_gnt", dbg_gnt, 1);
      dbg_req = 0;
      tick();
      chk("late_dbg_rdata", dbg_rdata, 32'hA000_0003);
      tick();
      chk("late_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
